// File: rtl/canv_pix_pipe_pkg.sv
// rtl/canv_pix_pipe_pkg.sv - shared pixel-depth codes and helpers for the canvas pixel pipe
package canv_pix_pipe_pkg;

    typedef enum logic [2:0] {
        BPP_1  = 3'd0,
        BPP_2  = 3'd1,
        BPP_4  = 3'd2,
        BPP_8  = 3'd3,
        BPP_16 = 3'd4
    } bpp_e;

    localparam logic [2:0] BPP_L2_DIRECT = 3'd4;

    // Unused codes 5-7 fall back to the 4bpp code.
    function automatic logic [2:0] bpp_log2(input logic [2:0] code);
        case (code)
            BPP_1:   return 3'd0;
            BPP_2:   return 3'd1;
            BPP_4:   return 3'd2;
            BPP_8:   return 3'd3;
            BPP_16:  return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/canv_pix_pipe_delay.sv
// rtl/canv_pix_pipe_delay.sv - fixed-depth shift register with async active-low reset
module canv_pix_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/canv_pix_pipe.sv
// rtl/canv_pix_pipe.sv - display pixel pipe: unpack, palette/transparency, CLUT, background composite
module canv_pix_pipe
    import canv_pix_pipe_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int BPC      = 5,
    parameter int CORDW    = 16,
    parameter int CIDXW    = 8,
    parameter int VRAM_LAT = 2,
    parameter int CLUT_LAT = 2,
    localparam int PIDW    = $clog2(WORD),
    localparam int COLRW   = 3 * BPC
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic              frame_start,
    input  logic [CORDW-1:0]  dx,
    input  logic [CORDW-1:0]  dy,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    input  logic [PIDW-1:0]   pix_id,
    input  logic              canv_paint,
    input  logic [WORD-1:0]   vram_dout,
    output logic [CIDXW-1:0]  clut_addr,
    input  logic [COLRW-1:0]  clut_dout,
    input  logic [2:0]        cfg_bpp,
    input  logic [CIDXW-1:0]  cfg_pal_bank,
    input  logic              cfg_trans_en,
    input  logic [CIDXW-1:0]  cfg_trans_idx,
    input  logic [COLRW-1:0]  cfg_bg_colr,
    output logic [CORDW-1:0]  disp_x,
    output logic [CORDW-1:0]  disp_y,
    output logic              disp_hsync,
    output logic              disp_vsync,
    output logic              disp_de,
    output logic              disp_frame,
    output logic [BPC-1:0]    disp_r,
    output logic [BPC-1:0]    disp_g,
    output logic [BPC-1:0]    disp_b
);

    localparam int AW = PIDW + 1 + 3;
    localparam int BW = 3 + COLRW;

    logic [2:0]       sh_l2;
    logic [CIDXW-1:0] sh_bank;
    logic             sh_trans_en;
    logic [CIDXW-1:0] sh_trans_idx;
    logic [COLRW-1:0] sh_bg;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sh_l2        <= '0;
            sh_bank      <= '0;
            sh_trans_en  <= 1'b0;
            sh_trans_idx <= '0;
            sh_bg        <= '0;
        end else if (frame_start) begin
            sh_l2        <= bpp_log2(cfg_bpp);
            sh_bank      <= cfg_pal_bank;
            sh_trans_en  <= cfg_trans_en;
            sh_trans_idx <= cfg_trans_idx;
            sh_bg        <= cfg_bg_colr;
        end
    end

    // Depth travels with each pixel so in-flight pixels finish in the mode they started in.
    logic [PIDW-1:0] a_pix_id;
    logic            a_paint;
    logic [2:0]      a_l2;

    canv_pix_pipe_delay #(.WIDTH(AW), .DEPTH(VRAM_LAT)) u_stage_a (
        .clk   (clk_pix),
        .rst_n (rst_pix_n),
        .d     ({pix_id, canv_paint, sh_l2}),
        .q     ({a_pix_id, a_paint, a_l2})
    );

    logic [PIDW-1:0]  shift;
    logic [CIDXW-1:0] win;
    logic [CIDXW-1:0] mask;
    logic [CIDXW-1:0] raw;
    logic [COLRW-1:0] direct;
    logic             is16;
    logic             trans;

    // Shift is taken mod WORD, which drops pix_id bits beyond the word's capacity at this depth.
    always_comb begin
        shift  = a_pix_id << a_l2;
        win    = CIDXW'(vram_dout >> shift);
        direct = COLRW'(vram_dout >> shift);
        case (a_l2)
            3'd0:    mask = CIDXW'(1);
            3'd1:    mask = CIDXW'(3);
            3'd2:    mask = CIDXW'(15);
            default: mask = CIDXW'(255);
        endcase
        raw       = win & mask;
        is16      = (a_l2 == BPP_L2_DIRECT);
        trans     = !is16 && sh_trans_en && (raw == sh_trans_idx);
        clut_addr = is16 ? '0 : raw + sh_bank;
    end

    logic             b_paint;
    logic             b_trans;
    logic             b_is16;
    logic [COLRW-1:0] b_direct;

    canv_pix_pipe_delay #(.WIDTH(BW), .DEPTH(CLUT_LAT)) u_stage_b (
        .clk   (clk_pix),
        .rst_n (rst_pix_n),
        .d     ({a_paint, trans, is16, direct}),
        .q     ({b_paint, b_trans, b_is16, b_direct})
    );

    logic [COLRW-1:0] colr;

    always_comb begin
        if (!b_paint || b_trans) colr = sh_bg;
        else if (b_is16)         colr = b_direct;
        else                     colr = clut_dout;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            disp_x     <= '0;
            disp_y     <= '0;
            disp_hsync <= 1'b0;
            disp_vsync <= 1'b0;
            disp_de    <= 1'b0;
            disp_frame <= 1'b0;
            disp_r     <= '0;
            disp_g     <= '0;
            disp_b     <= '0;
        end else begin
            disp_x     <= dx;
            disp_y     <= dy;
            disp_hsync <= hsync;
            disp_vsync <= vsync;
            disp_de    <= de;
            disp_frame <= frame_start;
            disp_r     <= de ? colr[3*BPC-1:2*BPC] : '0;
            disp_g     <= de ? colr[2*BPC-1:BPC]   : '0;
            disp_b     <= de ? colr[BPC-1:0]       : '0;
        end
    end

endmodule
